bcd_counter_n: RTL and testbench
================================

// Module: bcd_counter_n
// PURPOSE
//   Parametrised N-digit BCD up/down counter with programmable modulus, sync load/clear, carry/borrow pulses.
//   Successor to the fixed 2-digit 00..99 up-counter; used for timers, clock dividers and display counters.
//   Cascadable: CO/BO of one instance drive CE of the next (same CLK).
// PARAMETERS
//   DIGITS   2   number of BCD digits, legal 1..8; count width W = 4*DIGITS
// PORTS
//   CLK    in   1   clock, all state updates on rising edge
//   RST_N  in   1   asynchronous active-low reset
//   CE     in   1   count enable; one step per CLK edge while high
//   DIR    in   1   1 = count up, 0 = count down
//   CLR    in   1   synchronous clear to 0
//   LD     in   1   synchronous load of LDV
//   LDV    in   W   BCD load value
//   MAXV   in   W   BCD terminal value (modulus-1); 0 is legal (counter stays 0)
//   CNT    out  W   current count, BCD, digit 0 in CNT[3:0]
//   CO     out  1   carry: terminal-count pulse in up direction (combinational)
//   BO     out  1   borrow: terminal-count pulse in down direction (combinational)
// BEHAVIOUR
//   - Reset (RST_N=0, async, any time incl. mid-count): CNT=0 immediately; CO/BO follow from inputs with CNT=0.
//   - Priority per edge: CLR > LD > CE. CE=0 with CLR=LD=0: CNT holds.
//   - CLR=1: CNT<=0 regardless of LD/CE.
//   - LD=1 (CLR=0): CNT<=LDV, each digit >9 replaced by 9; load value may exceed MAXV.
//   - Up step (CE=1,DIR=1): if CNT>=MAXV -> CNT<=0 (wrap); else BCD +1 (digit 9->0 with carry into next digit).
//   - Down step (CE=1,DIR=0): if CNT==0 -> CNT<=MAXV; else BCD -1 (digit 0->9 with borrow from next digit).
//   - CNT>MAXV (after load or MAXV change): up wraps to 0 on next step; down decrements normally.
//   - Compare CNT vs MAXV as unsigned W-bit values (valid for legal BCD).
//   - Invalid BCD digits in MAXV are not corrected; behaviour follows the compare rule above.
//   - CO = CE & DIR & ~CLR & ~LD & (CNT>=MAXV); BO = CE & ~DIR & ~CLR & ~LD & (CNT==0).
//   - CO/BO: zero-latency, same cycle as the wrapping step.
//   - Latency: CNT reflects CLR/LD/step one edge after the request; DIR change effective on same edge.
//   - CNT never holds an invalid BCD digit except via MAXV wrap-to-MAXV with invalid MAXV.
// CONFIGURATION
//   BCD_CNT_SAT_EN defined: saturating mode.
//     - Up at CNT>=MAXV: CNT holds (or, if CNT>MAXV, becomes MAXV).
//     - Down at 0: CNT holds 0.
//     - CO/BO still asserted on each such attempted step (overflow/underflow indication).
//   BCD_CNT_SAT_EN undefined: wrap-around as specified above; no saturation logic present.
// TESTING
//   T1 reset: RST_N=0 mid-count at CNT=37 -> CNT=00 without clock edge; release, CE=1,DIR=1 -> 01,02 on successive edges.
//   T2 up wrap DIGITS=2, MAXV=59: count from 57 -> 58,59,00; CO=1 only in cycle CNT=59; digit carry 09->10 correct.
//   T3 down wrap MAXV=59: from 01 -> 00 then 59; BO=1 only while CNT=00; 10->09 borrow correct.
//   T4 priority: CLR=1,LD=1,CE=1 at CNT=42 -> 00, CO=BO=0; LD=1,CE=1,LDV=8'h7A -> CNT=79 (digit clamp), no step.
//   T5 out-of-range: MAXV=20, load 35, up step -> 00 with CO=1; MAXV=20, load 35, down step -> 34, BO=0.
//   T6 BCD_CNT_SAT_EN: MAXV=99 at 99 up -> stays 99, CO=1; at 00 down -> stays 00, BO=1; without macro -> 00 / 99.

Source files
------------

// File: rtl/bcd_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_counter_n
//   N-digit BCD up/down counter with a programmable terminal value.
//   Supports synchronous clear and load, and combinational carry/borrow
//   pulses so that instances can be cascaded (CO/BO -> CE of the next stage).
//
// Parameters
//   DIGITS  number of BCD digits (1..8); count width W = 4*DIGITS
//
// Ports
//   CLK    in   1  clock, rising edge
//   RST_N  in   1  asynchronous active-low reset (CNT -> 0)
//   CE     in   1  count enable, one step per edge
//   DIR    in   1  1 = up, 0 = down
//   CLR    in   1  synchronous clear (highest priority)
//   LD     in   1  synchronous load of LDV (digits > 9 clamp to 9)
//   LDV    in   W  BCD load value
//   MAXV   in   W  BCD terminal value (modulus - 1)
//   CNT    out  W  current count, digit 0 in CNT[3:0]
//   CO     out  1  carry: up step taken at CNT >= MAXV
//   BO     out  1  borrow: down step taken at CNT == 0
//
// Configuration
//   BCD_CNT_SAT_EN  when defined, the counter saturates instead of wrapping:
//                   up at/above MAXV settles on MAXV, down at 0 stays at 0.
//                   CO/BO still flag each attempted overflow/underflow.
// ---------------------------------------------------------------------------
module bcd_counter_n #(
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CE,
    input  logic                  DIR,
    input  logic                  CLR,
    input  logic                  LD,
    input  logic [4*DIGITS-1:0]   LDV,
    input  logic [4*DIGITS-1:0]   MAXV,
    output logic [4*DIGITS-1:0]   CNT,
    output logic                  CO,
    output logic                  BO
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] cnt_inc;
    logic [W-1:0] cnt_dec;
    logic [W-1:0] ldv_clamp;
    logic [W-1:0] up_term;
    logic [W-1:0] dn_term;
    logic [W-1:0] cnt_nxt;
    logic         at_max;
    logic         at_zero;

    // Unsigned W-bit compare; correct ordering for legal BCD values.
    assign at_max  = (CNT >= MAXV);
    assign at_zero = (CNT == '0);

    // Ripple BCD increment: a digit at 9 (or an invalid digit) rolls to 0
    // and passes the carry on.
    always_comb begin : bcd_inc
        logic carry;
        carry   = 1'b1;
        cnt_inc = CNT;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (CNT[4*i +: 4] >= 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = CNT[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Ripple BCD decrement: a digit at 0 rolls to 9 and borrows.
    always_comb begin : bcd_dec
        logic borrow;
        borrow  = 1'b1;
        cnt_dec = CNT;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (CNT[4*i +: 4] == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = CNT[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin : load_clamp
        ldv_clamp = LDV;
        for (int i = 0; i < DIGITS; i++) begin
            if (LDV[4*i +: 4] > 4'd9) begin
                ldv_clamp[4*i +: 4] = 4'd9;
            end
        end
    end

    // Value taken when a step hits the terminal condition.
`ifdef BCD_CNT_SAT_EN
    // Up at/above MAXV settles on MAXV (holds if already equal).
    assign up_term = MAXV;
    assign dn_term = '0;
`else
    assign up_term = '0;
    assign dn_term = MAXV;
`endif

    always_comb begin
        cnt_nxt = CNT;
        if (CLR) begin
            cnt_nxt = '0;
        end else if (LD) begin
            cnt_nxt = ldv_clamp;
        end else if (CE) begin
            if (DIR) begin
                cnt_nxt = at_max ? up_term : cnt_inc;
            end else begin
                cnt_nxt = at_zero ? dn_term : cnt_dec;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CNT <= '0;
        end else begin
            CNT <= cnt_nxt;
        end
    end

    assign CO = CE &  DIR & ~CLR & ~LD & at_max;
    assign BO = CE & ~DIR & ~CLR & ~LD & at_zero;

endmodule

// File: tb/tb_bcd_counter_n.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_n
//   Directed and random checks of bcd_counter_n (DIGITS = 2). Expected counts
//   come from an integer-domain reference model and are queued when a step is
//   driven, then popped and compared after the clock edge. Directed steps add
//   constant checks for the documented corner cases.
// ---------------------------------------------------------------------------
module tb_bcd_counter_n;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         ce;
    logic         dir;
    logic         clr;
    logic         ld;
    logic [W-1:0] ldv;
    logic [W-1:0] maxv;
    logic [W-1:0] cnt;
    logic         co;
    logic         bo;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_cnt;
    logic         last_co;
    logic         last_bo;

    bcd_counter_n #(.DIGITS(DIGITS)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .CE   (ce),
        .DIR  (dir),
        .CLR  (clr),
        .LD   (ld),
        .LDV  (ldv),
        .MAXV (maxv),
        .CNT  (cnt),
        .CO   (co),
        .BO   (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r = '0;
        int x = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] model_next(input logic [W-1:0] c,
                                                input logic k_clr, k_ld, k_ce, k_dir,
                                                input logic [W-1:0] k_ldv, k_max);
        logic [W-1:0] l;
        if (k_clr) return '0;
        if (k_ld) begin
            l = k_ldv;
            for (int i = 0; i < DIGITS; i++)
                if (l[4*i +: 4] > 4'd9) l[4*i +: 4] = 4'd9;
            return l;
        end
        if (!k_ce) return c;
        if (k_dir) begin
`ifdef BCD_CNT_SAT_EN
            if (c >= k_max) return k_max;
`else
            if (c >= k_max) return '0;
`endif
            return to_bcd(to_int(c) + 1);
        end
`ifdef BCD_CNT_SAT_EN
        if (c == '0) return '0;
`else
        if (c == '0) return k_max;
`endif
        return to_bcd(to_int(c) - 1);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Drive one cycle's controls, check CO/BO before the edge, queue the
    // expected count and check it after the edge.
    task automatic step(input string tag, input logic s_clr, s_ld, s_ce, s_dir,
                        input logic [W-1:0] s_ldv, s_max);
        logic e_co, e_bo;
        logic [W-1:0] got;
        clr  = s_clr;
        ld   = s_ld;
        ce   = s_ce;
        dir  = s_dir;
        ldv  = s_ldv;
        maxv = s_max;
        #1;
        e_co = s_ce &  s_dir & ~s_clr & ~s_ld & (model_cnt >= s_max);
        e_bo = s_ce & ~s_dir & ~s_clr & ~s_ld & (model_cnt == '0);
        last_co = co;
        last_bo = bo;
        chk1({tag, "_co"}, co, e_co);
        chk1({tag, "_bo"}, bo, e_bo);
        exp_q.push_back(model_next(model_cnt, s_clr, s_ld, s_ce, s_dir, s_ldv, s_max));
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({tag, "_cnt"}, cnt, got);
        model_cnt = got;
    endtask

    task automatic up(input string tag, input logic [W-1:0] m);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b1, '0, m);
    endtask

    task automatic dn(input string tag, input logic [W-1:0] m);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0, '0, m);
    endtask

    task automatic load(input string tag, input logic [W-1:0] v, input logic [W-1:0] m);
        step(tag, 1'b0, 1'b1, 1'b0, 1'b0, v, m);
    endtask

    initial begin
        logic [W-1:0] rm;
        rst_n = 1'b0;
        ce = 1'b0; dir = 1'b0; clr = 1'b0; ld = 1'b0;
        ldv = '0; maxv = 8'h99;
        model_cnt = '0;
        last_co = 1'b0; last_bo = 1'b0;
        #12;
        chk("reset_cnt", cnt, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: async reset mid-count
        load("t1_ld", 8'h35, 8'h99);
        up("t1_up", 8'h99);
        up("t1_up", 8'h99);
        chk("t1_at37", cnt, 8'h37);
        #2 rst_n = 1'b0;
        #1 chk("t1_async", cnt, 8'h00);
        model_cnt = '0;
        rst_n = 1'b1;
        up("t1_a", 8'h99);
        chk("t1_01", cnt, 8'h01);
        up("t1_b", 8'h99);
        chk("t1_02", cnt, 8'h02);

        // T2: up wrap at MAXV=59, digit carry
        load("t2_ld", 8'h57, 8'h59);
        up("t2_a", 8'h59); chk("t2_58", cnt, 8'h58); chk1("t2_co57", last_co, 1'b0);
        up("t2_b", 8'h59); chk("t2_59", cnt, 8'h59); chk1("t2_co58", last_co, 1'b0);
        up("t2_c", 8'h59); chk("t2_00", cnt, 8'h00); chk1("t2_co59", last_co, 1'b1);
        load("t2_ld9", 8'h09, 8'h59);
        up("t2_d", 8'h59); chk("t2_10", cnt, 8'h10);

        // T3: down wrap and digit borrow
        load("t3_ld", 8'h01, 8'h59);
        dn("t3_a", 8'h59); chk("t3_00", cnt, 8'h00); chk1("t3_bo01", last_bo, 1'b0);
        dn("t3_b", 8'h59); chk1("t3_bo00", last_bo, 1'b1);
`ifndef BCD_CNT_SAT_EN
        chk("t3_59", cnt, 8'h59);
`endif
        load("t3_ld10", 8'h10, 8'h59);
        dn("t3_c", 8'h59); chk("t3_09", cnt, 8'h09);

        // T4: priority and load clamp
        load("t4_ld", 8'h42, 8'h42);
        step("t4_clr", 1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h42);
        chk("t4_00", cnt, 8'h00);
        chk1("t4_co", last_co, 1'b0);
        chk1("t4_bo", last_bo, 1'b0);
        step("t4_ldce", 1'b0, 1'b1, 1'b1, 1'b1, 8'h7A, 8'h42);
        chk("t4_79", cnt, 8'h79);
        load("t4_ldff", 8'hFF, 8'h42);
        chk("t4_99", cnt, 8'h99);
        step("t4_hold", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h42);
        chk("t4_hold", cnt, 8'h99);

        // T5: count above MAXV
        load("t5_ld", 8'h35, 8'h20);
        up("t5_up", 8'h20);
        chk1("t5_co", last_co, 1'b1);
`ifdef BCD_CNT_SAT_EN
        chk("t5_sat", cnt, 8'h20);
`else
        chk("t5_00", cnt, 8'h00);
`endif
        load("t5_ld2", 8'h35, 8'h20);
        dn("t5_dn", 8'h20);
        chk("t5_34", cnt, 8'h34);
        chk1("t5_bo", last_bo, 1'b0);

        // T6: terminal behaviour, wrap or saturate
        load("t6_ld", 8'h99, 8'h99);
        up("t6_up", 8'h99);
        chk1("t6_co", last_co, 1'b1);
`ifdef BCD_CNT_SAT_EN
        chk("t6_up99", cnt, 8'h99);
`else
        chk("t6_up00", cnt, 8'h00);
`endif
        load("t6_ld0", 8'h00, 8'h99);
        dn("t6_dn", 8'h99);
        chk1("t6_bo", last_bo, 1'b1);
`ifdef BCD_CNT_SAT_EN
        chk("t6_dn00", cnt, 8'h00);
`else
        chk("t6_dn99", cnt, 8'h99);
`endif

        // MAXV = 0: counter stays at 0 in both directions
        load("m0_ld", 8'h00, 8'h00);
        up("m0_up", 8'h00); chk("m0_up", cnt, 8'h00); chk1("m0_co", last_co, 1'b1);
        dn("m0_dn", 8'h00); chk("m0_dn", cnt, 8'h00); chk1("m0_bo", last_bo, 1'b1);

        // Random mix against the reference model
        rm = 8'h59;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) rm = to_bcd($urandom_range(0, 99));
            step("rnd",
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 W'($urandom_range(0, 255)),
                 rm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
